// File: rtl/serial_mag_comp.sv
// Bit-serial MSB-first unsigned magnitude comparator with start/done handshake.
// Stops at the first differing bit and reports a registered one-hot lt/gt/eq result.
module serial_mag_comp #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             gt,
   output logic             eq
);

   localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state, state_nx;
   logic [WIDTH-1:0] a_r, a_nx;
   logic [WIDTH-1:0] b_r, b_nx;
   logic [IDX_W-1:0] idx, idx_nx;
   logic             lt_nx, gt_nx, eq_nx;
   logic             busy_nx, done_nx;
   logic             a_bit_c, b_bit_c;

   assign a_bit_c = a_r[idx];
   assign b_bit_c = b_r[idx];

   // State and registered outputs; reset abandons any compare in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         a_r   <= '0;
         b_r   <= '0;
         idx   <= IDX_MSB;
         lt    <= 1'b0;
         gt    <= 1'b0;
         eq    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         a_r   <= a_nx;
         b_r   <= b_nx;
         idx   <= idx_nx;
         lt    <= lt_nx;
         gt    <= gt_nx;
         eq    <= eq_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nx = state;
      a_nx     = a_r;
      b_nx     = b_r;
      idx_nx   = idx;
      lt_nx    = lt;
      gt_nx    = gt;
      eq_nx    = eq;

      case (state)
         S_IDLE: begin
            if (start) begin
               a_nx     = a_in;
               b_nx     = b_in;
               idx_nx   = IDX_MSB;
               lt_nx    = 1'b0;
               gt_nx    = 1'b0;
               eq_nx    = 1'b0;
               state_nx = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // First differing bit from the top decides; equal bits walk down
            if (a_bit_c != b_bit_c) begin
               lt_nx    = b_bit_c;
               gt_nx    = a_bit_c;
               state_nx = S_DONE;
            end else if (idx == '0) begin
               eq_nx    = 1'b1;
               state_nx = S_DONE;
            end else begin
               idx_nx   = idx - IDX_W'(1);
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      busy_nx = (state_nx != S_IDLE);
      done_nx = (state_nx == S_DONE);
   end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp: directed cases plus 1000 random
// back-to-back compares against an arithmetic reference (result and latency).
module tb_serial_mag_comp;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy, done, lt, gt, eq;

   int n_assert = 0;
   int n_fail   = 0;

   serial_mag_comp #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .lt    (lt),
      .gt    (gt),
      .eq    (eq)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle away from the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: expected {lt,gt,eq} and start-to-done latency in cycles
   function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (int'(a) < int'(b)) return 3'b100;
      if (int'(a) > int'(b)) return 3'b010;
      return 3'b001;
   endfunction

   function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] d;
      d = a ^ b;
      if (d == '0) return WIDTH + 1;
      for (int k = WIDTH - 1; k >= 0; k--)
         if (d[k]) return WIDTH - k + 1;
      return WIDTH + 1;
   endfunction

   // One compare: start in the current cycle, wait (bounded) for done, check it all
   task automatic run_cmp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int lat;
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      cyc();
      start = 1'b0;
      a_in  = ~a;
      b_in  = ~b;
      lat   = 1;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      while (!done && lat < int'(WIDTH) + 4) begin
         cyc();
         lat++;
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(ref_lat(a, b)));
      chk({tag, "_res"}, 32'({lt, gt, eq}), 32'(ref_res(a, b)));
      cyc();
      chk({tag, "_done1cyc"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_hold"}, 32'({lt, gt, eq}), 32'(ref_res(a, b)));
   endtask

   initial begin
      int dones;
      logic [WIDTH-1:0] ra, rb, mask;
      int unsigned mode, kk;

      rst   = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;

      // Reset then idle
      cyc();
      cyc();
      chk("reset_out", 32'({busy, done, lt, gt, eq}), 32'd0);
      rst = 1'b0;
      cyc();
      cyc();
      chk("idle_hold", 32'({busy, done, lt, gt, eq}), 32'd0);

      // MSB decides, LSB decides, equal
      run_cmp("msb", 8'h80, 8'h7F);
      cyc();
      chk("msb_hold_later", 32'({lt, gt, eq}), 32'b010);
      run_cmp("lsb", 8'h12, 8'h13);
      run_cmp("equal", 8'hA5, 8'hA5);

      // Start and operand changes while busy are ignored
      a_in  = 8'h12;
      b_in  = 8'h13;
      start = 1'b1;
      cyc();
      start = 1'b0;
      dones = 0;
      cyc();
      a_in  = 8'h00;
      b_in  = 8'hFF;
      start = 1'b1;
      cyc();
      start = 1'b0;
      a_in  = 8'hFF;
      b_in  = 8'h00;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            dones++;
            chk("ign_res", 32'({lt, gt, eq}), 32'b100);
         end
         cyc();
      end
      chk("ign_one_done", 32'(dones), 32'd1);
      chk("ign_idle", 32'(busy), 32'd0);

      // Reset in the 4th SHIFT cycle abandons the compare
      a_in  = 8'h01;
      b_in  = 8'h01;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_out", 32'({busy, done, lt, gt, eq}), 32'd0);
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) dones++;
         cyc();
      end
      chk("midrst_no_done", 32'(dones), 32'd0);
      run_cmp("after_rst", 8'h03, 8'h02);

      // Back-to-back random compares, biased to cover every deciding bit
      for (int n = 0; n < 1000; n++) begin
         ra   = WIDTH'($urandom);
         mode = $urandom_range(0, 3);
         kk   = $urandom_range(0, WIDTH - 1);
         mask = WIDTH'((1 << (kk + 1)) - 1);
         case (mode)
            0:       rb = WIDTH'($urandom);
            1:       rb = ra;
            default: rb = (ra & ~mask) | (WIDTH'($urandom) & mask);
         endcase
         run_cmp("rand", ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_mag_comp.md
# serial_mag_comp

Bit-serial magnitude comparator controller for the two-operand compare path. It drives the one-bit, priority-override comparison slice from the other side: it presents operand bits MSB-first, carries the previous slice's less/greater decision back in as the override, and terminates as soon as the outcome is fixed. It returns a registered one-hot result (less / greater / equal) with a start/done handshake, so the multi-bit compare needs no parallel comparator tree.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a compare; sampled only in IDLE
- a_in  in  WIDTH  operand A, captured on the accepting edge
- b_in  in  WIDTH  operand B, captured on the accepting edge
- busy  out  1  high in SHIFT and DONE states
- done  out  1  one-cycle pulse; result valid this cycle and held after
- lt  out  1  A < B (slice output l1 sense)
- gt  out  1  A > B (slice output l2 sense)
- eq  out  1  A == B (slice output l3 sense)

## Operation
- States: IDLE, SHIFT, DONE; reset state IDLE.
- IDLE: if start=1 at an edge → capture a_in/b_in into internal registers A_r/B_r, set idx=WIDTH-1, clear lt/gt/eq to 000, go SHIFT. Otherwise hold.
- SHIFT, per cycle, compare A_r[idx] vs B_r[idx] with the slice priority:
  - A bit 0, B bit 1 → lt=1, go DONE (A<B override latched).
  - A bit 1, B bit 0 → gt=1, go DONE.
  - bits equal, idx>0 → idx decrements, stay SHIFT.
  - bits equal, idx=0 → eq=1, go DONE.
- DONE: done=1 for exactly this cycle, then go IDLE unconditionally. start is ignored in DONE.
- lt/gt/eq are registered and written only on the edge entering DONE (or cleared on accept). After done they hold until the next accepted start or reset. In every state they are one-hot or all-zero; all-zero means no result.
- start while busy=1 is ignored; there is no queueing.
- Operands are unsigned. idx is ceil(log2(WIDTH)) bits and never wraps below 0.
- a_in/b_in changes after the accepting edge do not affect the compare in progress.

## Timing
- Reset values: busy=0, done=0, lt=0, gt=0, eq=0, state=IDLE, idx=WIDTH-1.
- rst=1 at any edge, including mid-SHIFT or in DONE, forces the reset values on that edge. The in-flight compare is abandoned and no done is issued. rst has priority over start.
- start accepted at edge E0. Compare of bit k happens in cycle E0+(WIDTH-k). done is high in the cycle after the deciding compare.
- Latency start→done: first differing bit at position k gives WIDTH-k+1 cycles. Best case (MSB differs) is 2 cycles. Worst case (operands equal, or only the LSB differs) is WIDTH+1 cycles.
- busy rises the cycle after acceptance and falls the cycle after done.
- Back-to-back: start high in the cycle following done (state IDLE) is accepted. Minimum issue interval is 3 cycles.
- start held high continuously starts a new compare in each IDLE cycle.

## Test plan
- Reset then idle: rst=1 for 2 cycles, start=0 → busy/done/lt/gt/eq all 0 and held.
- MSB decides, WIDTH=8: A=0x80, B=0x7F, start 1 cycle → done 2 cycles after acceptance with gt=1, lt=0, eq=0. Result holds after done.
- LSB decides: A=0x12, B=0x13 → lt=1 with done at WIDTH+1=9 cycles. Then A=0xA5, B=0xA5 → eq=1, 9 cycles.
- Ignored start and operand change: a compare is in SHIFT; pulse start with A=0x00, B=0xFF and change a_in/b_in → the original result is unaffected and exactly one done pulse occurs.
- Reset mid-operation: A=0x01, B=0x01; assert rst in the 4th SHIFT cycle → next cycle all outputs 0, no done. A fresh start with A=0x03, B=0x02 → gt=1 at 9 cycles.
- Back-to-back and randomized: start in the cycle after each done. 1000 random unsigned pairs are checked against a reference compare for the one-hot result, the latency formula WIDTH-k+1, and a single-cycle done.
